// File: rtl/gpio_ins_sender.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// gpio_ins_sender
//
// Transmit end of the GPIO instruction-load link. A host-side board uses it
// to stream a program image, word by word, from a local synchronous image
// memory onto a 32-bit GPIO data bus. Each word is framed by a write strobe
// with a guaranteed setup time before it and hold time after it.
//
// Per-word sequence: READ (2) -> SETUP (SETUP_CYC) -> STROBE (STB_CYC)
// -> HOLD (HOLD_CYC), then either the next word or FIN (1 cycle, done pulse).
//
// Parameters:
//   AW        word-address width; the image holds at most 2^AW words
//   SETUP_CYC cycles data is stable before gpio_we rises (>= 1)
//   STB_CYC   cycles gpio_we is held high (>= 1)
//   HOLD_CYC  cycles data is held after gpio_we falls (>= 1)
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   start      single-cycle start pulse, ignored while busy
//   words      number of words to send (0 .. 2^AW), sampled on accepted start
//   mem_addr   read address to the image memory (registered)
//   mem_data   image memory read data, valid one cycle after mem_addr changes
//   gpio_data  instruction word driven onto the link (registered)
//   gpio_we    link write strobe, active high (direct flop output)
//   busy       transfer in progress, including the FIN cycle
//   done       one-cycle pulse in the FIN cycle
//   idx        number of words fully sent in the current or last transfer
// ---------------------------------------------------------------------------
module gpio_ins_sender #(
   parameter int AW        = 6,
   parameter int SETUP_CYC = 2,
   parameter int STB_CYC   = 4,
   parameter int HOLD_CYC  = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW:0]   words,
   output logic [AW-1:0] mem_addr,
   input  logic [31:0]   mem_data,
   output logic [31:0]   gpio_data,
   output logic          gpio_we,
   output logic          busy,
   output logic          done,
   output logic [AW:0]   idx
);

   // The read phase is fixed: one cycle for the address to reach the memory,
   // one cycle for the memory's registered data to come back.
   localparam int READ_CYC = 2;

   // The phase counter only has to span the longest phase.
   localparam int MAX_A   = (SETUP_CYC > STB_CYC)  ? SETUP_CYC : STB_CYC;
   localparam int MAX_B   = (HOLD_CYC  > READ_CYC) ? HOLD_CYC  : READ_CYC;
   localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CW-1:0] READ_LAST  = CW'(READ_CYC - 1);
   localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
   localparam logic [CW-1:0] STB_LAST   = CW'(STB_CYC - 1);
   localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_READ   = 3'd1,
      S_SETUP  = 3'd2,
      S_STROBE = 3'd3,
      S_HOLD   = 3'd4,
      S_FIN    = 3'd5
   } state_t;

   state_t          state;
   state_t          next_state;

   logic [CW-1:0]   cnt;
   logic [AW:0]     n;

   logic            phase_last;
   logic            last_word;
   logic            accept;

   logic [CW-1:0]   cnt_d;
   logic [AW:0]     n_d;
   logic [AW:0]     idx_d;
   logic [AW-1:0]   mem_addr_d;
   logic [31:0]     gpio_data_d;
   logic            gpio_we_d;
   logic            busy_d;
   logic            done_d;

   // A start pulse only counts when the block is idle; this is what makes
   // start during a transfer (including the FIN cycle) harmless.
   assign accept = (state == S_IDLE) && start;

   // The word that just finished its hold phase was the last one when the
   // post-increment count reaches the latched length.
   assign last_word = ((idx + (AW+1)'(1)) == n);

   // Flags the final cycle of whichever timed phase the FSM is in.
   always_comb begin
      phase_last = 1'b0;
      case (state)
         S_READ:   phase_last = (cnt == READ_LAST);
         S_SETUP:  phase_last = (cnt == SETUP_LAST);
         S_STROBE: phase_last = (cnt == STB_LAST);
         S_HOLD:   phase_last = (cnt == HOLD_LAST);
         default:  phase_last = 1'b0;
      endcase
   end

   // State register; reset lands in IDLE from anywhere, mid-strobe included.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. An empty image skips straight to FIN so done still
   // pulses once. Unused encodings fall back to IDLE.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               next_state = (words == '0) ? S_FIN : S_READ;
            end
         end
         S_READ: begin
            if (phase_last) next_state = S_SETUP;
         end
         S_SETUP: begin
            if (phase_last) next_state = S_STROBE;
         end
         S_STROBE: begin
            if (phase_last) next_state = S_HOLD;
         end
         S_HOLD: begin
            if (phase_last) next_state = last_word ? S_FIN : S_READ;
         end
         S_FIN: begin
            next_state = S_IDLE;
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   // Output and datapath next values. Every output is derived from the next
   // state so that it can be registered and still line up with the phase it
   // belongs to; in particular gpio_we comes straight from a flop.
   always_comb begin
      cnt_d       = '0;
      n_d         = n;
      idx_d       = idx;
      mem_addr_d  = mem_addr;
      gpio_data_d = gpio_data;
      gpio_we_d   = (next_state == S_STROBE);
      busy_d      = (next_state != S_IDLE);
      done_d      = (next_state == S_FIN);

      // The phase counter restarts whenever the FSM changes phase and
      // rests at zero while idle.
      if ((next_state == state) && (state != S_IDLE)) begin
         cnt_d = cnt + CW'(1);
      end

      if (accept) begin
         n_d        = words;
         idx_d      = '0;
         mem_addr_d = '0;
      end

      // The memory data is taken on the final read edge only, so the link
      // data never moves outside the read phase.
      if ((state == S_READ) && phase_last) begin
         gpio_data_d = mem_data;
      end

      // After the last word the address is left alone so it still shows the
      // final word's address and is never re-read from zero.
      if ((state == S_HOLD) && phase_last) begin
         idx_d = idx + (AW+1)'(1);
         if (!last_word) begin
            mem_addr_d = mem_addr + AW'(1);
         end
      end
   end

   // Registered outputs and internal counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         n         <= '0;
         idx       <= '0;
         mem_addr  <= '0;
         gpio_data <= '0;
         gpio_we   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         cnt       <= cnt_d;
         n         <= n_d;
         idx       <= idx_d;
         mem_addr  <= mem_addr_d;
         gpio_data <= gpio_data_d;
         gpio_we   <= gpio_we_d;
         busy      <= busy_d;
         done      <= done_d;
      end
   end

endmodule

// File: tb/tb_gpio_ins_sender.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_gpio_ins_sender
//
// Bench for gpio_ins_sender. Holds the image memory, a cycle-level reference
// model of the transfer timeline and a per-cycle compare process, plus
// directed scenarios with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_gpio_ins_sender;

   localparam int AW        = 6;
   localparam int SETUP_CYC = 2;
   localparam int STB_CYC   = 4;
   localparam int HOLD_CYC  = 2;
   localparam int PER       = 2 + SETUP_CYC + STB_CYC + HOLD_CYC;
   localparam int DEPTH     = 1 << AW;
   localparam int WE_ON     = 2 + SETUP_CYC;
   localparam int WE_OFF    = WE_ON + STB_CYC;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW:0]   words = '0;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_data;
   logic [31:0]   gpio_data;
   logic          gpio_we;
   logic          busy;
   logic          done;
   logic [AW:0]   idx;

   logic [31:0]   mem [DEPTH];

   int            checks = 0;
   int            errors = 0;

   int            rise_cyc[$];
   logic [31:0]   rise_data[$];

   gpio_ins_sender #(
      .AW        (AW),
      .SETUP_CYC (SETUP_CYC),
      .STB_CYC   (STB_CYC),
      .HOLD_CYC  (HOLD_CYC)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .words     (words),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .gpio_data (gpio_data),
      .gpio_we   (gpio_we),
      .busy      (busy),
      .done      (done),
      .idx       (idx)
   );

   always #5 clk = ~clk;

   // Synchronous image memory: data follows the address by one clock.
   always @(posedge clk) begin
      mem_data <= mem[mem_addr];
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: a transfer is a start time plus a length. The compare
   // process derives every output from the cycle offset into the transfer.
   bit            m_active;
   int            m_cyc;
   int            m_n;
   int            m_end;
   logic [31:0]   m_prev_data;
   logic [31:0]   last_data;
   logic [AW-1:0] last_addr;
   logic [AW:0]   last_idx;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active    = 1'b0;
         m_cyc       = 0;
         m_n         = 0;
         m_end       = 0;
         m_prev_data = '0;
         last_data   = '0;
         last_addr   = '0;
         last_idx    = '0;
      end else begin : upd
         bit was_active;
         was_active = m_active;
         if (m_active) begin
            if (m_cyc == m_end) begin
               m_active  = 1'b0;
               last_data = (m_n == 0) ? m_prev_data : mem[m_n-1];
               last_addr = (m_n == 0) ? '0 : AW'(m_n - 1);
               last_idx  = (AW+1)'(m_n);
            end else begin
               m_cyc++;
            end
         end
         if (!was_active && start) begin
            m_active    = 1'b1;
            m_cyc       = 0;
            m_n         = int'(words);
            m_end       = PER * m_n;
            m_prev_data = last_data;
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   logic        we_prev   = 1'b0;
   logic [31:0] data_prev = '0;

   always @(negedge clk) begin : cmp
      logic [31:0]   e_data;
      logic [AW-1:0] e_addr;
      logic [AW:0]   e_idx;
      logic          e_we;
      logic          e_busy;
      logic          e_done;
      int            w;
      int            p;
      if (!m_active) begin
         e_data = last_data;
         e_addr = last_addr;
         e_idx  = last_idx;
         e_we   = 1'b0;
         e_busy = 1'b0;
         e_done = 1'b0;
      end else if (m_cyc == m_end) begin
         e_busy = 1'b1;
         e_done = 1'b1;
         e_we   = 1'b0;
         e_idx  = (AW+1)'(m_n);
         e_addr = (m_n == 0) ? '0 : AW'(m_n - 1);
         e_data = (m_n == 0) ? m_prev_data : mem[m_n-1];
      end else begin
         w      = m_cyc / PER;
         p      = m_cyc % PER;
         e_busy = 1'b1;
         e_done = 1'b0;
         e_idx  = (AW+1)'(w);
         e_addr = AW'(w);
         e_we   = (p >= WE_ON) && (p < WE_OFF);
         if (p >= 2)      e_data = mem[w];
         else if (w == 0) e_data = m_prev_data;
         else             e_data = mem[w-1];
      end
      checkOutput("busy",      32'(busy),      32'(e_busy));
      checkOutput("done",      32'(done),      32'(e_done));
      checkOutput("gpio_we",   32'(gpio_we),   32'(e_we));
      checkOutput("idx",       32'(idx),       32'(e_idx));
      checkOutput("mem_addr",  32'(mem_addr),  32'(e_addr));
      checkOutput("gpio_data", gpio_data,      e_data);
      if (we_prev && gpio_we) begin
         checkOutput("data_stable_in_strobe", gpio_data, data_prev);
      end
      we_prev   = gpio_we;
      data_prev = gpio_data;
   end

   // Pulses start for one cycle; returns at the negedge of transfer cycle 0.
   task automatic applyStimulus(input logic [AW:0] w);
      start = 1'b1;
      words = w;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Runs one transfer, records strobe rises, returns the done cycle.
   task automatic runTransfer(input int w, input int budget, output int dcyc);
      logic prev;
      prev = 1'b0;
      dcyc = -1;
      rise_cyc.delete();
      rise_data.delete();
      applyStimulus((AW+1)'(w));
      for (int c = 0; c <= budget; c++) begin
         if (c > 0) @(negedge clk);
         if (gpio_we && !prev) begin
            rise_cyc.push_back(c);
            rise_data.push_back(gpio_data);
         end
         prev = gpio_we;
         if (done) begin
            dcyc = c;
            break;
         end
      end
      if (dcyc < 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL done_timeout: no done within %0d cycles", budget);
      end
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int dcyc;
      int rises;
      int dones;
      logic prev;

      for (int i = 0; i < DEPTH; i++) mem[i] = '0;

      // Reset to idle, then an empty transfer.
      repeat (3) @(negedge clk);
      checkOutput("rst_busy",  32'(busy),     32'd0);
      checkOutput("rst_done",  32'(done),     32'd0);
      checkOutput("rst_we",    32'(gpio_we),  32'd0);
      checkOutput("rst_idx",   32'(idx),      32'd0);
      checkOutput("rst_addr",  32'(mem_addr), 32'd0);
      checkOutput("rst_data",  gpio_data,     32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      runTransfer(0, 5, dcyc);
      checkOutput("t1_done_cycle", 32'(dcyc), 32'd0);
      checkOutput("t1_no_strobe",  32'(rise_cyc.size()), 32'd0);
      checkOutput("t1_idx",        32'(idx),  32'd0);

      // Single word with explicit per-cycle timing.
      mem[0] = 32'h2008_0005;
      applyStimulus(1);
      for (int c = 0; c <= 11; c++) begin
         if (c > 0) @(negedge clk);
         checkOutput("t2_we",   32'(gpio_we), 32'(c >= 4 && c <= 7));
         checkOutput("t2_done", 32'(done),    32'(c == 10));
         if (c >= 2) checkOutput("t2_data", gpio_data, 32'h2008_0005);
      end
      checkOutput("t2_idx", 32'(idx), 32'd1);

      // Four-word image.
      for (int i = 0; i < 4; i++) mem[i] = 32'h1111_1111 * (i + 1);
      runTransfer(4, 60, dcyc);
      checkOutput("t3_strobes", 32'(rise_cyc.size()), 32'd4);
      for (int k = 0; k < rise_cyc.size() && k < 4; k++) begin
         checkOutput("t3_data", rise_data[k], 32'h1111_1111 * (k + 1));
         if (k > 0) checkOutput("t3_spacing", 32'(rise_cyc[k] - rise_cyc[k-1]), 32'd10);
      end
      checkOutput("t3_addr", 32'(mem_addr), 32'd3);
      checkOutput("t3_idx",  32'(idx),      32'd4);

      // Full depth.
      for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i);
      runTransfer(DEPTH, 700, dcyc);
      checkOutput("t4_done_cycle", 32'(dcyc), 32'd640);
      checkOutput("t4_strobes", 32'(rise_cyc.size()), 32'd64);
      for (int k = 0; k < rise_cyc.size() && k < DEPTH; k++) begin
         checkOutput("t4_data", rise_data[k], 32'(k));
      end
      checkOutput("t4_idx",  32'(idx),      32'd64);
      checkOutput("t4_addr", 32'(mem_addr), 32'd63);

      // Start pulses during a transfer and in the FIN cycle.
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      rises = 0;
      dones = 0;
      prev  = 1'b0;
      applyStimulus(3);
      for (int c = 0; c <= 40; c++) begin
         if (c > 0) @(negedge clk);
         if (gpio_we && !prev) rises++;
         prev = gpio_we;
         if (done) dones++;
         checkOutput("t5_done_at_30", 32'(done), 32'(c == 30));
         start = (c == 3 || c == 15 || c == 20 || c == 30);
         words = $urandom_range(1, DEPTH);
      end
      start = 1'b0;
      checkOutput("t5_strobes", 32'(rises), 32'd3);
      checkOutput("t5_dones",   32'(dones), 32'd1);
      checkOutput("t5_idle",    32'(busy),  32'd0);

      // Asynchronous reset in the middle of the second word's strobe.
      applyStimulus(4);
      for (int c = 0; c < 40; c++) begin
         if (idx == 1 && gpio_we) break;
         @(negedge clk);
      end
      checkOutput("t6_in_strobe", 32'(gpio_we), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("t6_we_async",   32'(gpio_we),  32'd0);
      checkOutput("t6_busy_async", 32'(busy),     32'd0);
      checkOutput("t6_idx_async",  32'(idx),      32'd0);
      checkOutput("t6_addr_async", 32'(mem_addr), 32'd0);
      checkOutput("t6_data_async", gpio_data,     32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      mem[0] = 32'hCAFE_F00D;
      runTransfer(1, 20, dcyc);
      checkOutput("t6_restart_strobes", 32'(rise_cyc.size()), 32'd1);
      if (rise_cyc.size() > 0) checkOutput("t6_restart_data", rise_data[0], 32'hCAFE_F00D);

      // Randomized transfers with noise on start and words.
      for (int t = 0; t < 20; t++) begin
         int w;
         bit seen;
         for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
         w    = ($urandom_range(0, 9) == 0) ? $urandom_range(0, DEPTH) : $urandom_range(0, 8);
         seen = 1'b0;
         applyStimulus((AW+1)'(w));
         for (int c = 0; c <= PER * DEPTH + 10; c++) begin
            if (done) begin
               seen = 1'b1;
               break;
            end
            start = ($urandom_range(0, 7) == 0);
            words = (AW+1)'($urandom_range(0, DEPTH));
            @(negedge clk);
         end
         if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL rand_timeout: transfer %0d never finished", t);
         end
         start = ($urandom_range(0, 1) == 1);
         @(negedge clk);
         start = 1'b0;
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/gpio_ins_sender.md
Name: gpio_ins_sender

Overview:
- Transmit end of the GPIO instruction-load link. A host-side board uses it to stream a program image into the MIPS board's instruction memory.
- Each word is fetched from a local synchronous ROM or RAM port and driven onto a 32-bit GPIO data bus.
- Each word is qualified by a write-enable strobe with guaranteed setup and hold around it.
- Started by a one-shot button pulse. Progress outputs (busy, done, word index) feed the LED and 7-seg decoders.

Parameters:
- AW, 6, word-address width; the image holds at most 2^AW words.
- SETUP_CYC, 2, cycles data is stable before GPIO_WE rises (≥1).
- STB_CYC, 4, cycles GPIO_WE is held high (≥1).
- HOLD_CYC, 2, cycles data is held after GPIO_WE falls (≥1).

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous active-low reset.
- START  in  1  single-cycle start pulse.
- WORDS  in  AW+1  number of words to send (0 to 2^AW); sampled on accepted START.
- MEM_ADDR  out  AW  read address to the local image memory.
- MEM_DATA  in  32  memory read data; valid one cycle after MEM_ADDR changes.
- GPIO_DATA  out  32  instruction word to the link.
- GPIO_WE  out  1  write strobe to the link; active high.
- BUSY  out  1  transfer in progress.
- DONE  out  1  one-cycle pulse when the transfer completes.
- IDX  out  AW+1  number of words fully sent in the current or last transfer.

Behaviour:
- Reset (RST=0, asynchronous, any state):
  - State=IDLE.
  - MEM_ADDR, GPIO_DATA and IDX are 0.
  - GPIO_WE, BUSY and DONE are 0.
  - Internal counters are 0.
  - Reset mid-strobe drops GPIO_WE immediately; no partial-word retry.
- All outputs are registered. GPIO_WE is a direct flop output and must be glitch-free.
- Main sequence:
  - IDLE: on START=1, latch WORDS into N, clear IDX and the address counter, and assert BUSY.
    - If N=0: go straight to FIN; DONE pulses the cycle after START.
    - Otherwise go to READ.
  - READ: 2 cycles. MEM_ADDR=current index for the whole state. MEM_DATA is captured into GPIO_DATA on the last edge of READ. Next state is SETUP.
  - SETUP: SETUP_CYC cycles, GPIO_WE=0, GPIO_DATA stable. Next state is STROBE.
  - STROBE: STB_CYC cycles, GPIO_WE=1. Next state is HOLD.
  - HOLD: HOLD_CYC cycles, GPIO_WE=0, GPIO_DATA still stable. On the last cycle, IDX increments.
    - If IDX+1==N: go to FIN.
    - Otherwise increment MEM_ADDR and go to READ.
  - FIN: 1 cycle. DONE=1, BUSY=0 at the next edge. Next state is IDLE.
- Per-word period is 2+SETUP_CYC+STB_CYC+HOLD_CYC cycles (10 at defaults).
- From accepted START, the first GPIO_WE rise occurs after 2+SETUP_CYC cycles (4 at defaults).
- GPIO_DATA changes only in READ, never while GPIO_WE=1, and never within SETUP_CYC/HOLD_CYC of a strobe edge.
- START while BUSY is ignored and does not extend or restart the transfer.
- A START in the FIN cycle is also ignored.
- WORDS changing during a transfer has no effect.
- WORDS=2^AW sends every address 0..2^AW-1. MEM_ADDR wraps only internally after the last word; it is not re-read.
- After FIN:
  - GPIO_DATA keeps the last word.
  - MEM_ADDR keeps the last address.
  - IDX keeps N.
- The state encoding is an implementation choice, but no unreachable state may drive GPIO_WE=1; the default branch returns to IDLE.

Test Plan:
- Reset → idle
  - Stimulus: hold RST=0 for 3 cycles, release.
  - Required: all outputs 0, BUSY=0.
  - Then START with WORDS=0: DONE=1 exactly one cycle later, GPIO_WE never rises, IDX=0.
- Single word
  - Stimulus: MEM[0]=0x2008_0005, WORDS=1, START.
  - Required: GPIO_DATA=0x20080005 from cycle 2. GPIO_WE high in cycles 4–7. DONE in cycle 10. IDX=1.
- Multi-word
  - Stimulus: 4-word image 0x11111111, 0x22222222, 0x33333333, 0x44444444.
  - Required:
    - Exactly 4 GPIO_WE pulses, 10 cycles apart, with data matching in order.
    - Data never changes while GPIO_WE=1.
    - MEM_ADDR ends at 3, IDX=4.
- Full depth
  - Stimulus: WORDS=64 at AW=6, with MEM[i]=i.
  - Required: 64 strobes with data 0..63 and no re-read of address 0. DONE at cycle 640. IDX=64.
- START during transfer
  - Stimulus: START pulses at cycles 3, 15 and 20 of a WORDS=3 run (ending at cycle 30), plus one START in the FIN cycle.
  - Required: exactly 3 strobes, a single DONE, no restart.
- Reset mid-strobe
  - Stimulus: assert RST asynchronously in the middle of the second word's STROBE.
  - Required: GPIO_WE falls without waiting for CLK; outputs return to reset values.
  - After release, a new START sends from address 0.
